// File: rtl/l2_pkg.sv
// Shared types and character constants for the Lab2 command parser.
package l2_pkg;

   typedef enum logic [2:0] {
      StGetA,
      StGetOp,
      StGetB,
      StGetT,
      StStart,
      StWait,
      StErr,
      StSend
   } l2_state_e;

   localparam logic [7:0] ChPlus  = 8'h2B;
   localparam logic [7:0] ChMinus = 8'h2D;
   localparam logic [7:0] ChCr    = 8'h0D;
   localparam logic [7:0] ChErr   = 8'h3F;
   localparam logic [7:0] ChTmo   = 8'h21;
   localparam logic [3:0] DigitHi = 4'h3;

   // Any byte in 8'h30..8'h3F counts as a digit; the adder only uses the low nibble.
   function automatic logic is_digit(input logic [7:0] b);
      return b[7:4] == DigitHi;
   endfunction

endpackage

// File: rtl/l2_tx_hold.sv
// One-entry output register: holds data/valid stable until the consumer accepts it.
module l2_tx_hold (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] data_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic [7:0] data_o
);

   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/l2_cmd_parser.sv
// Parses "<digit><op><digit><CR>", drives the Lab2 adder and returns its result byte.
module l2_cmd_parser
   import l2_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16  // must be >= 8
) (
   input  logic       clk,
   input  logic       Gl_rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] Gl_r1,
   output logic [7:0] Gl_r2,
   output logic       Gl_subtract,
   output logic       Gl_adder_start,
   input  logic [7:0] L2_adder_data,
   input  logic       L2_adder_rdy,
   output logic       busy,
   output logic       rx_drop
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   l2_state_e       state_q, state_d;
   logic [7:0]      r1_q, r1_d;
   logic [7:0]      r2_q, r2_d;
   logic            sub_q, sub_d;
   logic            start_q, start_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tx_load;
   logic [7:0]      tx_load_data;

   always_comb begin
      state_d      = state_q;
      r1_d         = r1_q;
      r2_d         = r2_q;
      sub_d        = sub_q;
      start_d      = 1'b0;
      cnt_d        = cnt_q;
      tx_load      = 1'b0;
      tx_load_data = ChErr;
      unique case (state_q)
         StGetA: begin
            if (rx_valid) begin
               if (is_digit(rx_data)) begin
                  r1_d    = rx_data;
                  state_d = StGetOp;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StGetOp: begin
            if (rx_valid) begin
               if (rx_data == ChPlus) begin
                  sub_d   = 1'b0;
                  state_d = StGetB;
               end else if (rx_data == ChMinus) begin
                  sub_d   = 1'b1;
                  state_d = StGetB;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StGetB: begin
            if (rx_valid) begin
               if (is_digit(rx_data)) begin
                  r2_d    = rx_data;
                  state_d = StGetT;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StGetT: begin
            if (rx_valid) begin
               if (rx_data == ChCr) begin
                  start_d = 1'b1;
                  state_d = StStart;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StStart: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // A ready pulse beats an expiry landing in the same cycle.
            if (L2_adder_rdy) begin
               tx_load      = 1'b1;
               tx_load_data = L2_adder_data;
               state_d      = StSend;
            end else begin
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntW'(TIMEOUT - 1)) begin
                  tx_load      = 1'b1;
                  tx_load_data = ChTmo;
                  state_d      = StSend;
               end
            end
         end
         StErr: begin
            tx_load      = 1'b1;
            tx_load_data = ChErr;
            state_d      = StSend;
         end
         StSend: begin
            if (tx_valid && tx_ready) begin
               state_d = StGetA;
            end
         end
         default: state_d = StGetA;
      endcase
   end

   always_ff @(posedge clk or negedge Gl_rst_n) begin
      if (!Gl_rst_n) begin
         state_q <= StGetA;
         r1_q    <= 8'h00;
         r2_q    <= 8'h00;
         sub_q   <= 1'b0;
         start_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         sub_q   <= sub_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
      end
   end

   l2_tx_hold u_tx_hold (
      .clk_i   (clk),
      .rst_ni  (Gl_rst_n),
      .load_i  (tx_load),
      .data_i  (tx_load_data),
      .ready_i (tx_ready),
      .valid_o (tx_valid),
      .data_o  (tx_data)
   );

   assign Gl_r1          = r1_q;
   assign Gl_r2          = r2_q;
   assign Gl_subtract    = sub_q;
   assign Gl_adder_start = start_q;
   assign busy           = (state_q != StGetA);
   // Bytes arriving while a command is executing or its reply is pending are thrown away.
   assign rx_drop        = rx_valid &&
                           (state_q inside {StStart, StWait, StErr, StSend});

endmodule

// File: tb/tb_l2_cmd_parser.sv
// Bench for l2_cmd_parser: directed commands, adder stub, scoreboard on the tx handshake.
module tb_l2_cmd_parser;

   logic       clk = 1'b0;
   logic       Gl_rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] Gl_r1;
   logic [7:0] Gl_r2;
   logic       Gl_subtract;
   logic       Gl_adder_start;
   logic [7:0] L2_adder_data;
   logic       L2_adder_rdy;
   logic       busy;
   logic       rx_drop;

   int         total = 0;
   int         bad = 0;
   int         n_wait;
   logic [7:0] sb_q[$];
   logic [7:0] mon_exp;

   logic       adder_en;
   logic       stub_rdy;
   logic [7:0] stub_data;
   logic       man_rdy;
   logic [7:0] man_data;

   assign L2_adder_rdy  = stub_rdy | man_rdy;
   assign L2_adder_data = man_rdy ? man_data : stub_data;

   always #5 clk = ~clk;

   l2_cmd_parser #(.TIMEOUT(16)) dut (
      .clk            (clk),
      .Gl_rst_n       (Gl_rst_n),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .Gl_r1          (Gl_r1),
      .Gl_r2          (Gl_r2),
      .Gl_subtract    (Gl_subtract),
      .Gl_adder_start (Gl_adder_start),
      .L2_adder_data  (L2_adder_data),
      .L2_adder_rdy   (L2_adder_rdy),
      .busy           (busy),
      .rx_drop        (rx_drop)
   );

   // Lab2 adder: carry/borrow shows up as 8'h5x instead of 8'h3x.
   function automatic logic [7:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic sub);
      logic [4:0] s;
      s = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      return {(s[4] ? 4'h5 : 4'h3), s[3:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b);
      send_byte(a);
      send_byte(op);
      send_byte(b);
      send_byte(8'h0D);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || tx_valid) && n < 80) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_reached", {30'd0, busy, tx_valid}, 32'd0);
   endtask

   // Adder stub: answers 4 cycles after the start pulse, when enabled.
   initial begin : stub
      logic [7:0] res;
      stub_rdy  = 1'b0;
      stub_data = 8'h00;
      forever begin
         @(negedge clk);
         if (Gl_rst_n && Gl_adder_start && adder_en) begin
            res = adder_model(Gl_r1[3:0], Gl_r2[3:0], Gl_subtract);
            repeat (4) @(posedge clk);
            #1;
            stub_rdy  = 1'b1;
            stub_data = res;
            @(posedge clk);
            #1;
            stub_rdy  = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (Gl_rst_n && tx_valid && tx_ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tx: got %0h expected nothing", tx_data);
         end else begin
            mon_exp = sb_q.pop_front();
            check("tx_data", {24'd0, tx_data}, {24'd0, mon_exp});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      Gl_rst_n = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;
      adder_en = 1'b1;
      man_rdy  = 1'b0;
      man_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'h00);
      check("rst_r1", {24'd0, Gl_r1}, 32'h00);
      check("rst_r2", {24'd0, Gl_r2}, 32'h00);
      check("rst_sub", {31'd0, Gl_subtract}, 32'd0);
      check("rst_start", {31'd0, Gl_adder_start}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      Gl_rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 3+4
      sb_q.push_back(8'h37);
      send_cmd(8'h33, 8'h2B, 8'h34);
      check("add_start_on", {31'd0, Gl_adder_start}, 32'd1);
      check("add_r1", {24'd0, Gl_r1}, 32'h33);
      check("add_r2", {24'd0, Gl_r2}, 32'h34);
      check("add_sub", {31'd0, Gl_subtract}, 32'd0);
      check("add_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      check("add_start_off", {31'd0, Gl_adder_start}, 32'd0);
      wait_idle();

      // 9+9 with carry
      sb_q.push_back(8'h52);
      send_cmd(8'h39, 8'h2B, 8'h39);
      wait_idle();

      // "3x" error, then recovery
      sb_q.push_back(8'h3F);
      send_byte(8'h33);
      send_byte(8'h78);
      wait_idle();
      check("err_r1_held", {24'd0, Gl_r1}, 32'h33);
      sb_q.push_back(8'h32);
      send_cmd(8'h31, 8'h2B, 8'h31);
      wait_idle();

      // Timeout with a late rdy while the '!' is still pending
      adder_en = 1'b0;
      tx_ready = 1'b0;
      sb_q.push_back(8'h21);
      send_cmd(8'h31, 8'h2B, 8'h31);
      n_wait = 0;
      while (!tx_valid && n_wait < 40) begin
         @(posedge clk);
         #1;
         n_wait++;
      end
      // WAIT entry is one cycle after START; tx_valid 16 cycles after that.
      check("tmo_cycles", n_wait, 32'd17);
      check("tmo_data", {24'd0, tx_data}, 32'h21);
      man_rdy  = 1'b1;
      man_data = 8'h55;
      @(posedge clk);
      #1;
      man_rdy = 1'b0;
      check("late_rdy_data", {24'd0, tx_data}, 32'h21);
      check("late_rdy_valid", {31'd0, tx_valid}, 32'd1);
      tx_ready = 1'b1;
      wait_idle();
      adder_en = 1'b1;

      // 5-2 under backpressure, with dropped rx bytes
      tx_ready = 1'b0;
      sb_q.push_back(8'h33);
      send_cmd(8'h35, 8'h2D, 8'h32);
      check("sub_sel", {31'd0, Gl_subtract}, 32'd1);
      n_wait = 0;
      while (!tx_valid && n_wait < 20) begin
         @(posedge clk);
         #1;
         n_wait++;
      end
      for (int k = 0; k < 5; k++) begin
         rx_data  = 8'h41 + 8'(k);
         rx_valid = 1'b1;
         #1;
         check("bp_rx_drop", {31'd0, rx_drop}, 32'd1);
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
         check("bp_valid", {31'd0, tx_valid}, 32'd1);
         check("bp_data", {24'd0, tx_data}, 32'h33);
      end
      tx_ready = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back: new command right after the handshake
      check("b2b_idle", {31'd0, busy}, 32'd0);
      sb_q.push_back(8'h37);
      send_cmd(8'h33, 8'h2B, 8'h34);
      wait_idle();

      // Reset in the middle of WAIT
      adder_en = 1'b0;
      send_cmd(8'h32, 8'h2B, 8'h33);
      repeat (3) @(posedge clk);
      #2;
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      Gl_rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("mid_rst_tx_data", {24'd0, tx_data}, 32'h00);
      check("mid_rst_r1", {24'd0, Gl_r1}, 32'h00);
      check("mid_rst_r2", {24'd0, Gl_r2}, 32'h00);
      check("mid_rst_start", {31'd0, Gl_adder_start}, 32'd0);
      @(posedge clk);
      #1;
      Gl_rst_n = 1'b1;
      adder_en = 1'b1;
      @(posedge clk);
      #1;

      // Recovery after reset
      sb_q.push_back(8'h32);
      send_cmd(8'h31, 8'h2B, 8'h31);
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      check("sb_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
